// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I pipeline control path.
//   - opcode constants for every instruction class the decoder recognises
//   - write-back source select and ALU-operation class encodings
//   - control bundles carried by the ID/EX, EX/MEM and MEM/WB registers
// ---------------------------------------------------------------------------
package rv32i_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Write-back source select.
   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10,
      WB_IMM = 2'b11
   } wb_sel_e;

   // ALU-operation class handed to the ALU control unit.
   typedef enum logic [1:0] {
      ULA_ADD    = 2'b00,
      ULA_BRANCH = 2'b01,
      ULA_R      = 2'b10,
      ULA_I      = 2'b11
   } ula_op_e;

   // Full control bundle produced by decode and held in ID/EX.
   typedef struct packed {
      logic    valid;
      logic    branch;
      logic    jump;
      logic    mux_ula;
      logic    a_pc;
      ula_op_e ula_op;
      logic    mem_rd;
      logic    mem_wr;
      logic    reg_wr;
      wb_sel_e wb_sel;
   } ctrl_t;

   // Subset still needed once the instruction has left EX.
   typedef struct packed {
      logic    valid;
      logic    mem_rd;
      logic    mem_wr;
      logic    reg_wr;
      wb_sel_e wb_sel;
   } mem_ctrl_t;

   // Subset still needed in WB.
   typedef struct packed {
      logic    valid;
      logic    reg_wr;
      wb_sel_e wb_sel;
   } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational opcode decode for the ID stage.
// Ports:
//   i_valid     ID instruction valid
//   i_opcode    7-bit opcode
//   i_rd_zero   destination register is x0 (suppresses reg_wr)
//   o_ctrl      control bundle; all-zero bubble when invalid or illegal
//   o_illegal   valid opcode that is not in the decode table
//   o_use_rs1   instruction reads rs1
//   o_use_rs2   instruction reads rs2
// ---------------------------------------------------------------------------
module ctrl_decode
   import rv32i_pkg::*;
(
   input  logic       i_valid,
   input  logic [6:0] i_opcode,
   input  logic       i_rd_zero,
   output ctrl_t      o_ctrl,
   output logic       o_illegal,
   output logic       o_use_rs1,
   output logic       o_use_rs2
);

   ctrl_t w_raw;
   logic  w_legal;
   logic  w_rs1;
   logic  w_rs2;

   // Table lookup on the opcode alone; validity is applied afterwards.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_raw   = '0;
      w_legal = 1'b1;
      w_rs1   = 1'b0;
      w_rs2   = 1'b0;
      case (i_opcode)
         OP_R: begin
            w_raw.ula_op = ULA_R;
            w_raw.reg_wr = 1'b1;
            w_raw.wb_sel = WB_ALU;
            w_rs1        = 1'b1;
            w_rs2        = 1'b1;
         end
         OP_I_ALU: begin
            w_raw.ula_op  = ULA_I;
            w_raw.mux_ula = 1'b1;
            w_raw.reg_wr  = 1'b1;
            w_raw.wb_sel  = WB_ALU;
            w_rs1         = 1'b1;
         end
         OP_LOAD: begin
            w_raw.mem_rd  = 1'b1;
            w_raw.ula_op  = ULA_ADD;
            w_raw.mux_ula = 1'b1;
            w_raw.reg_wr  = 1'b1;
            w_raw.wb_sel  = WB_MEM;
            w_rs1         = 1'b1;
         end
         OP_STORE: begin
            w_raw.mem_wr  = 1'b1;
            w_raw.ula_op  = ULA_ADD;
            w_raw.mux_ula = 1'b1;
            w_rs1         = 1'b1;
            w_rs2         = 1'b1;
         end
         OP_BRANCH: begin
            w_raw.branch = 1'b1;
            w_raw.ula_op = ULA_BRANCH;
            w_rs1        = 1'b1;
            w_rs2        = 1'b1;
         end
         OP_JAL: begin
            w_raw.jump   = 1'b1;
            w_raw.reg_wr = 1'b1;
            w_raw.wb_sel = WB_PC4;
         end
         OP_JALR: begin
            w_raw.jump    = 1'b1;
            w_raw.ula_op  = ULA_ADD;
            w_raw.mux_ula = 1'b1;
            w_raw.reg_wr  = 1'b1;
            w_raw.wb_sel  = WB_PC4;
            w_rs1         = 1'b1;
         end
         OP_LUI: begin
            w_raw.reg_wr = 1'b1;
            w_raw.wb_sel = WB_IMM;
         end
         OP_AUIPC: begin
            w_raw.a_pc    = 1'b1;
            w_raw.mux_ula = 1'b1;
            w_raw.ula_op  = ULA_ADD;
            w_raw.reg_wr  = 1'b1;
            w_raw.wb_sel  = WB_ALU;
         end
         default: w_legal = 1'b0;
      endcase
   end

   // Invalid or illegal slots collapse to a bubble; writes to x0 are dropped.
   always_comb begin
      o_ctrl = '0;
      if (i_valid && w_legal) begin
         o_ctrl       = w_raw;
         o_ctrl.valid = 1'b1;
         if (i_rd_zero) o_ctrl.reg_wr = 1'b0;
      end
   end

   assign o_illegal = i_valid & ~w_legal;
   assign o_use_rs1 = i_valid & w_legal & w_rs1;
   assign o_use_rs2 = i_valid & w_legal & w_rs2;

endmodule

// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe
// Control path of a 5-stage RV32I pipeline: decodes the ID instruction,
// carries its control bundle through ID/EX, EX/MEM and MEM/WB, and produces
// load-use stall and branch flush.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_valid, id_opcode            ID instruction and its opcode
//   id_rs1, id_rs2, id_rd          ID register indices
//   ex_branch_taken                branch/jump resolved taken in EX
//   stall, flush_ifid, id_illegal  combinational hazard/decode status
//   ex_*                           registered EX controls
//   mem_*                          registered MEM controls
//   wb_*                           registered WB controls
// ---------------------------------------------------------------------------
module ctrl_pipe
   import rv32i_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter int ULA_OP_W  = 2,
   parameter bit HAZARD_EN = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [6:0]          id_opcode,
   input  logic [REG_AW-1:0]   id_rs1,
   input  logic [REG_AW-1:0]   id_rs2,
   input  logic [REG_AW-1:0]   id_rd,
   input  logic                ex_branch_taken,
   output logic                stall,
   output logic                flush_ifid,
   output logic                id_illegal,
   output logic                ex_valid,
   output logic                ex_branch,
   output logic                ex_jump,
   output logic                ex_mux_ula,
   output logic                ex_a_pc,
   output logic [ULA_OP_W-1:0] ex_ula_op,
   output logic [REG_AW-1:0]   ex_rd,
   output logic                mem_valid,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic [REG_AW-1:0]   mem_rd_idx,
   output logic                wb_valid,
   output logic                wb_reg_wr,
   output logic [1:0]          wb_sel,
   output logic [REG_AW-1:0]   wb_rd
);

   ctrl_t             w_id_ctrl;
   logic              w_illegal;
   logic              w_use_rs1;
   logic              w_use_rs2;
   logic              w_load_use;
   logic              w_bubble;

   ctrl_t             r_ex;
   logic [REG_AW-1:0] r_ex_rd;
   mem_ctrl_t         r_mem;
   logic [REG_AW-1:0] r_mem_rd;
   wb_ctrl_t          r_wb;
   logic [REG_AW-1:0] r_wb_rd;

   ctrl_decode u_decode (
      .i_valid   (id_valid),
      .i_opcode  (id_opcode),
      .i_rd_zero (id_rd == '0),
      .o_ctrl    (w_id_ctrl),
      .o_illegal (w_illegal),
      .o_use_rs1 (w_use_rs1),
      .o_use_rs2 (w_use_rs2)
   );

   // A load in EX whose non-zero destination is read by the ID instruction
   // cannot forward in time, so ID must wait one cycle.
   assign w_load_use = id_valid && r_ex.valid && r_ex.mem_rd && (r_ex_rd != '0)
                    && ((w_use_rs1 && (id_rs1 == r_ex_rd))
                     || (w_use_rs2 && (id_rs2 == r_ex_rd)));

   // A taken branch kills the ID instruction anyway, so it overrides the stall.
   assign stall      = HAZARD_EN & w_load_use & ~ex_branch_taken;
   assign flush_ifid = ex_branch_taken;
   assign id_illegal = w_illegal;
   assign w_bubble   = ex_branch_taken | stall;

   // NOTE: all stage registers are reset, not only the valid bits, because
   // every registered control output must read zero while reset is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex     <= '0;
         r_ex_rd  <= '0;
         r_mem    <= '0;
         r_mem_rd <= '0;
         r_wb     <= '0;
         r_wb_rd  <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample the previous
         // value of the stage before it, giving a true one-edge shift.
         if (w_bubble) begin
            r_ex    <= '0;
            r_ex_rd <= '0;
         end else begin
            r_ex    <= w_id_ctrl;
            r_ex_rd <= w_id_ctrl.valid ? id_rd : '0;
         end
         r_mem    <= '{valid:  r_ex.valid,
                       mem_rd: r_ex.mem_rd,
                       mem_wr: r_ex.mem_wr,
                       reg_wr: r_ex.reg_wr,
                       wb_sel: r_ex.wb_sel};
         r_mem_rd <= r_ex_rd;
         r_wb     <= '{valid:  r_mem.valid,
                       reg_wr: r_mem.reg_wr,
                       wb_sel: r_mem.wb_sel};
         r_wb_rd  <= r_mem_rd;
      end
   end

   assign ex_valid   = r_ex.valid;
   assign ex_branch  = r_ex.branch;
   assign ex_jump    = r_ex.jump;
   assign ex_mux_ula = r_ex.mux_ula;
   assign ex_a_pc    = r_ex.a_pc;
   assign ex_ula_op  = ULA_OP_W'(r_ex.ula_op);
   assign ex_rd      = r_ex_rd;

   assign mem_valid  = r_mem.valid;
   assign mem_rd     = r_mem.mem_rd;
   assign mem_wr     = r_mem.mem_wr;
   assign mem_rd_idx = r_mem_rd;

   assign wb_valid   = r_wb.valid;
   assign wb_reg_wr  = r_wb.reg_wr;
   assign wb_sel     = r_wb.wb_sel;
   assign wb_rd      = r_wb_rd;

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter REG_AW, default 5, register-index width.
REQ-002 Parameter ULA_OP_W, default 2, width of the ALU-operation class code.
REQ-003 Parameter HAZARD_EN, default 1, enables load-use stall generation; 0 forces stall low.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 id_valid  in  1  ID-stage instruction is valid.
REQ-008 id_opcode  in  7  ID-stage opcode.
REQ-009 id_rs1, id_rs2, id_rd  in  REG_AW each  ID-stage register indices.
REQ-010 ex_branch_taken  in  1  branch or jump resolved taken in EX this cycle.
REQ-011 stall  out  1  hold PC and IF/ID (combinational).
REQ-012 flush_ifid  out  1  invalidate IF/ID (combinational; equals ex_branch_taken).
REQ-013 id_illegal  out  1  valid ID opcode not in the decode table (combinational).
REQ-014 ex_valid, ex_branch, ex_jump, ex_mux_ula, ex_a_pc  out  1 each  registered EX controls.
REQ-015 ex_ula_op  out  ULA_OP_W, and ex_rd  out  REG_AW  registered EX controls.
REQ-016 mem_valid, mem_rd, mem_wr  out  1 each, and mem_rd_idx  out  REG_AW  registered MEM controls.
REQ-017 wb_valid, wb_reg_wr  out  1 each, wb_sel  out  2, and wb_rd  out  REG_AW  registered WB controls.

Function
REQ-018 Decode: R 0110011: ula 10, mux_ula 0, reg_wr 1, wb_sel 00 (ALU).
REQ-019 Decode: I-ALU 0010011: ula 11, mux_ula 1, reg_wr 1, wb_sel 00.
REQ-020 Decode: load 0000011: mem_rd 1, ula 00, mux_ula 1, reg_wr 1, wb_sel 01 (MEM).
REQ-021 Decode: store 0100011: mem_wr 1, mem_rd 0, ula 00, mux_ula 1, reg_wr 0.
REQ-022 Decode: branch 1100011: branch 1, ula 01, mux_ula 0, reg_wr 0.
REQ-023 Decode: JAL 1101111: jump 1, reg_wr 1, wb_sel 10 (PC+4).
REQ-024 Decode: JALR 1100111: jump 1, ula 00, mux_ula 1, reg_wr 1, wb_sel 10.
REQ-025 Decode: LUI 0110111: reg_wr 1, wb_sel 11 (IMM); AUIPC 0010111: a_pc 1, mux_ula 1, ula 00, reg_wr 1, wb_sel 00.
REQ-026 Illegal or invalid (id_valid=0) opcodes decode to an all-zero bubble.
REQ-027 reg_wr is forced 0 when rd==0.
REQ-028 The control bundle advances ID->EX->MEM->WB, one stage per clk edge; WB sees ID decode 3 edges later.
REQ-029 rs1 is used by R, I-ALU, load, store, branch, JALR; rs2 by R, store, branch.
REQ-030 stall=1 iff HAZARD_EN, id_valid, ex_valid, EX mem_rd, ex_rd!=0, and ex_rd matches a used id_rs1 or id_rs2.
REQ-031 On stall, ID/EX loads a bubble while EX/MEM and MEM/WB advance normally.
REQ-032 On ex_branch_taken, ID/EX loads a bubble; flush has priority and stall is forced 0 that cycle.
REQ-033 A bubble carries every control bit and valid as 0.

Reset
REQ-034 rst asserted clears every stage register immediately; all registered outputs read 0.
REQ-035 Mid-operation rst discards all in-flight instructions; the first valid ID after release reaches EX on the next edge.

Structure
REQ-036 Opcode constants, wb_sel encodings, ula_op class codes, and the control-bundle struct live in shared package rv32i_pkg.
REQ-037 One sub-module, ctrl_decode, is purely combinational opcode decode; ctrl_pipe holds the stage registers and hazard logic.

Verification
REQ-038 lw x5 then add x6,x5,x1 back-to-back -> stall=1 for exactly one cycle, one EX bubble, add reaches WB with wb_sel 00 and wb_rd=6.
REQ-039 lw x0 followed by a use of x0 -> no stall; wb_reg_wr=0.
REQ-040 beq reaches EX with ex_branch_taken=1 while a dependent load-use is in ID -> stall=0, flush_ifid=1, next ex_valid=0.
REQ-041 sw then jal x1 -> MEM mem_wr=1, mem_rd=0; jal reaches WB with wb_sel 10 and wb_reg_wr=1.
REQ-042 Opcode 1111111 with id_valid=1 -> id_illegal=1, next EX controls all 0.
REQ-043 rst pulsed mid-stream with 3 instructions in flight -> all outputs 0 asynchronously; HAZARD_EN=0 build never asserts stall.
